// File: rtl/digit_scan_display.sv
// digit_scan_display: multiplexed seven-segment driver for a binary value.
// A load either starts an iterative shift-add-3 binary-to-BCD conversion
// (decimal) or takes the nibbles directly (hex). The finished digits are
// latched into a display register that a free-running refresh counter scans.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero digit (the last digit and dash overflow stay lit).
module digit_scan_display #(
  parameter int NUM_W     = 13,
  parameter int DIGITS    = 4,
  parameter int REFRESH_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_W-1:0]  num_in,
  input  logic              load,
  input  logic              hex_mode,
  output logic              busy,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_out
);

  // Decimal digits needed to hold the largest NUM_W-bit value.
  function automatic int dec_digits_f(input int w);
    longint unsigned m;
    int              n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (m != 64'd0) begin
        m = m / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int DEC_D  = dec_digits_f(NUM_W);
  // One spare digit above the shown ones keeps the overflow slice non-empty.
  localparam int TOT_D  = ((DEC_D > DIGITS) ? DEC_D : DIGITS) + 1;
  localparam int BCD_W  = 4 * TOT_D;
  localparam int DISP_W = 4 * DIGITS;
  localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(NUM_W + 1);

  // One double-dabble step: add 3 to every digit >= 5, then shift in_bit in.
  function automatic logic [BCD_W-1:0] dabble_step_f(input logic [BCD_W-1:0] b,
                                                     input logic             in_bit);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < TOT_D; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
    end
    return {r[BCD_W-2:0], in_bit};
  endfunction

  // Segment glyphs, active low, bit6 = a ... bit0 = g; codes above 9 blank in decimal.
  function automatic logic [6:0] seg_decode_f(input logic [3:0] d, input logic hex);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd10:   s = hex ? 7'b0001000 : 7'b1111111;
      4'd11:   s = hex ? 7'b1100000 : 7'b1111111;
      4'd12:   s = hex ? 7'b0110001 : 7'b1111111;
      4'd13:   s = hex ? 7'b1000010 : 7'b1111111;
      4'd14:   s = hex ? 7'b0110000 : 7'b1111111;
      4'd15:   s = hex ? 7'b0111000 : 7'b1111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic              busy_q,     busy_d;
  logic              mode_q,     mode_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [NUM_W-1:0]  shreg_q,    shreg_d;
  logic [BCD_W-1:0]  bcd_q,      bcd_d;
  logic [DISP_W-1:0] disp_q,     disp_d;
  logic              disp_hex_q, disp_hex_d;
  logic              dash_q,     dash_d;
  logic [REFRESH_W-1:0] ref_q;

  logic [BCD_W-1:0]  bcd_step;
  logic [DISP_W-1:0] hex_digits;
  logic [SCAN_W-1:0] scan_idx;
  logic [DIGITS-1:0] blank_s;

  assign bcd_step = dabble_step_f(bcd_q, shreg_q[NUM_W-1]);
  assign busy     = busy_q;

  // Hex digits are the low nibbles of the captured value, zero padded when narrow.
  generate
    if (DISP_W > NUM_W) begin : g_hex_pad
      assign hex_digits = {{(DISP_W-NUM_W){1'b0}}, shreg_q};
    end else if (DISP_W == NUM_W) begin : g_hex_eq
      assign hex_digits = shreg_q;
    end else begin : g_hex_trunc
      assign hex_digits = shreg_q[DISP_W-1:0];
    end
  endgenerate

  // Scan index is the top bits of the refresh counter (always 0 for one digit).
  generate
    if (DIGITS > 1) begin : g_scan
      assign scan_idx = ref_q[REFRESH_W-1 -: SCAN_W];
    end else begin : g_scan_one
      assign scan_idx = 1'b0;
    end
  endgenerate

  // Conversion control: accept loads when idle, step once per busy cycle, latch on the last.
  always_comb begin
    busy_d     = busy_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    disp_hex_d = disp_hex_q;
    dash_d     = dash_q;
    if (!busy_q) begin
      if (load) begin
        busy_d  = 1'b1;
        mode_d  = hex_mode;
        shreg_d = num_in;
        bcd_d   = '0;
        cnt_d   = hex_mode ? CNT_W'(1) : CNT_W'(NUM_W);
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      if (!mode_q) begin
        shreg_d = {shreg_q[NUM_W-2:0], 1'b0};
        bcd_d   = bcd_step;
      end else begin
        shreg_d = shreg_q;
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d     = 1'b0;
        disp_hex_d = mode_q;
        if (mode_q) begin
          disp_d = hex_digits;
          dash_d = 1'b0;
        end else begin
          disp_d = bcd_step[DISP_W-1:0];
          dash_d = |bcd_step[BCD_W-1:DISP_W];
        end
      end else begin
        busy_d = 1'b1;
      end
    end
  end

  // State registers; reset aborts any conversion and shows decimal zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bcd_q      <= '0;
      disp_q     <= '0;
      disp_hex_q <= 1'b0;
      dash_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      disp_hex_q <= disp_hex_d;
      dash_q     <= dash_d;
    end
  end

  // Free-running refresh counter, wraps naturally at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_q + REFRESH_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic above_s;
  // Blank zero digits above the most significant nonzero one, never the last or a dash.
  always_comb begin
    blank_s = '0;
    above_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      above_s    = above_s & (disp_q[4*k +: 4] == 4'd0);
      blank_s[k] = above_s & ~dash_q;
    end
  end
`else
  assign blank_s = '0;
`endif

  // Digit multiplexer: scan index 0 selects the most significant digit.
  always_comb begin
    Anode   = '1;
    LED_out = 7'b1111111;
    for (int k = 0; k < DIGITS; k++) begin
      if ((int'(scan_idx) == DIGITS - 1 - k) && !blank_s[k]) begin
        Anode[k] = 1'b0;
        LED_out  = dash_q ? 7'b1111110 : seg_decode_f(disp_q[4*k +: 4], disp_hex_q);
      end else begin
        Anode[k] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_display.sv
// Scoreboard bench for digit_scan_display: a 4-digit and a 3-digit instance,
// both with REFRESH_W=4. Expected displays are pushed when a load is driven
// and popped when busy falls, then compared over a full scan period.
`timescale 1ns/1ps
module tb_digit_scan_display;

  typedef struct packed {
    logic [7:0]  blen;
    logic [3:0]  lit;
    logic [27:0] seg;
  } exp_t;

  localparam logic [6:0] GLYPH [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] num_a = '0, num_b = '0;
  logic        load_a = 1'b0, load_b = 1'b0, hex_a = 1'b0, hex_b = 1'b0;
  logic        busy_a, busy_b;
  logic [3:0]  an_a;
  logic [2:0]  an_b;
  logic [6:0]  led_a, led_b;
  logic [3:0]  ref_m = 4'd0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        last_a;

  digit_scan_display #(.NUM_W(13), .DIGITS(4), .REFRESH_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .num_in(num_a), .load(load_a), .hex_mode(hex_a),
    .busy(busy_a), .Anode(an_a), .LED_out(led_a));

  digit_scan_display #(.NUM_W(13), .DIGITS(3), .REFRESH_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .num_in(num_b), .load(load_b), .hex_mode(hex_b),
    .busy(busy_b), .Anode(an_b), .LED_out(led_b));

  always #5 clk = ~clk;

  // Reference refresh counter: cleared by reset, +1 per rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_m <= 4'd0;
    else        ref_m <= ref_m + 4'd1;
  end

  function automatic exp_t make_exp(input int unsigned val, input bit hex, input int nd);
    exp_t        e;
    int unsigned v;
    int unsigned lim;
    int          d;
    bit          dash;
`ifdef LEADING_ZERO_BLANK_EN
    int          digs[4];
    bit          above;
`endif
    e = '0;
    e.blen = hex ? 8'd1 : 8'd13;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 32'd10;
    dash = !hex && (val >= lim);
    v = val;
    for (int k = 0; k < nd; k++) begin
      if (hex) begin d = int'(v & 32'hF); v = v >> 4; end
      else     begin d = int'(v % 32'd10); v = v / 32'd10; end
`ifdef LEADING_ZERO_BLANK_EN
      digs[k] = d;
`endif
      e.lit[k] = 1'b1;
      e.seg[7*k +: 7] = dash ? 7'b1111110 : GLYPH[d];
    end
`ifdef LEADING_ZERO_BLANK_EN
    above = 1'b1;
    for (int k = nd - 1; k >= 1; k--) begin
      above = above && (digs[k] == 0) && !dash;
      if (above) e.lit[k] = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic pulse_a(input int unsigned v, input bit h);
    @(negedge clk); num_a = v[12:0]; hex_a = h; load_a = 1'b1;
    @(negedge clk); load_a = 1'b0;
  endtask

  task automatic pulse_b(input int unsigned v, input bit h);
    @(negedge clk); num_b = v[12:0]; hex_b = h; load_b = 1'b1;
    @(negedge clk); load_b = 1'b0;
  endtask

  task automatic wait_busy_a(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic wait_busy_b(output int n);
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    exp_t e;
    int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    repeat (3) @(negedge clk);
    q_a.push_back(make_exp(0, 1'b0, 4));
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL reset_busy busy_a=%b busy_b=%b expected 0 0", busy_a, busy_b);
    end
    @(negedge clk); rst_n = 1'b1;
    e = q_a.pop_front();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led) begin
        errors++; $display("FAIL reset_scan idx=%0d Anode=%b LED_out=%b expected %b %b", idx, an_a, led_a, ex_an, ex_led);
      end
    end
    last_a = e;
  endtask

  task automatic test_decimal();
    int unsigned vals[3] = '{1234, 8191, 305};
    exp_t e; int n; int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    foreach (vals[i]) begin
      pulse_a(vals[i], 1'b0);
      q_a.push_back(make_exp(vals[i], 1'b0, 4));
      wait_busy_a(n);
      e = q_a.pop_front();
      checks++;
      if (n != int'(e.blen)) begin
        errors++; $display("FAIL dec_busy_len value=%0d got=%0d expected=%0d", vals[i], n, e.blen);
      end
      for (int c = 0; c < 16; c++) begin
        idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
        if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
        checks++;
        if (an_a !== ex_an || led_a !== ex_led) begin
          errors++; $display("FAIL dec_scan value=%0d idx=%0d Anode=%b LED_out=%b expected %b %b", vals[i], idx, an_a, led_a, ex_an, ex_led);
        end
        @(negedge clk);
      end
      last_a = e;
    end
  endtask

  task automatic test_hex();
    int unsigned vals[2] = '{32'h1ABF, 32'h00C3};
    exp_t e; int n; int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    foreach (vals[i]) begin
      pulse_a(vals[i], 1'b1);
      q_a.push_back(make_exp(vals[i], 1'b1, 4));
      wait_busy_a(n);
      e = q_a.pop_front();
      checks++;
      if (n != int'(e.blen)) begin
        errors++; $display("FAIL hex_busy_len value=%h got=%0d expected=%0d", vals[i], n, e.blen);
      end
      for (int c = 0; c < 16; c++) begin
        idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
        if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
        checks++;
        if (an_a !== ex_an || led_a !== ex_led) begin
          errors++; $display("FAIL hex_scan value=%h idx=%0d Anode=%b LED_out=%b expected %b %b", vals[i], idx, an_a, led_a, ex_an, ex_led);
        end
        @(negedge clk);
      end
      last_a = e;
    end
  endtask

  task automatic test_overflow();
    int unsigned vals[3] = '{999, 1000, 8191};
    exp_t e; int n; int idx;
    logic [2:0] ex_an; logic [6:0] ex_led;
    foreach (vals[i]) begin
      pulse_b(vals[i], 1'b0);
      q_b.push_back(make_exp(vals[i], 1'b0, 3));
      wait_busy_b(n);
      e = q_b.pop_front();
      checks++;
      if (n != int'(e.blen)) begin
        errors++; $display("FAIL ovf_busy_len value=%0d got=%0d expected=%0d", vals[i], n, e.blen);
      end
      for (int c = 0; c < 16; c++) begin
        idx = int'(ref_m[3:2]); ex_an = 3'b111; ex_led = 7'h7F;
        if (idx < 3 && e.lit[2-idx]) begin ex_an[2-idx] = 1'b0; ex_led = e.seg[7*(2-idx) +: 7]; end
        checks++;
        if (an_b !== ex_an || led_b !== ex_led) begin
          errors++; $display("FAIL ovf_scan value=%0d idx=%0d Anode=%b LED_out=%b expected %b %b", vals[i], idx, an_b, led_b, ex_an, ex_led);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e; int n; int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    pulse_a(42, 1'b0);
    q_a.push_back(make_exp(42, 1'b0, 4));
    // Display must hold the previous value while converting.
    for (int c = 0; c < 3; c++) begin
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (last_a.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = last_a.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led || busy_a !== 1'b1) begin
        errors++; $display("FAIL hold_during_busy idx=%0d busy=%b Anode=%b LED_out=%b expected 1 %b %b", idx, busy_a, an_a, led_a, ex_an, ex_led);
      end
      @(negedge clk);
    end
    num_a = 13'd77; load_a = 1'b1;
    @(negedge clk); load_a = 1'b0;
    wait_busy_a(n);
    e = q_a.pop_front();
    checks++;
    if (4 + n != int'(e.blen)) begin
      errors++; $display("FAIL ignore_busy_len got=%0d expected=%0d", 4 + n, e.blen);
    end
    for (int c = 0; c < 16; c++) begin
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led || busy_a !== 1'b0) begin
        errors++; $display("FAIL ignore_scan idx=%0d busy=%b Anode=%b LED_out=%b expected 0 %b %b", idx, busy_a, an_a, led_a, ex_an, ex_led);
      end
      @(negedge clk);
    end
    last_a = e;
  endtask

  task automatic test_leading();
    exp_t e; int n; int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    pulse_a(7, 1'b0);
    q_a.push_back(make_exp(7, 1'b0, 4));
    wait_busy_a(n);
    e = q_a.pop_front();
    checks++;
    if (n != int'(e.blen)) begin
      errors++; $display("FAIL lead_busy_len got=%0d expected=%0d", n, e.blen);
    end
    for (int c = 0; c < 16; c++) begin
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led) begin
        errors++; $display("FAIL lead_scan idx=%0d Anode=%b LED_out=%b expected %b %b", idx, an_a, led_a, ex_an, ex_led);
      end
      @(negedge clk);
    end
    last_a = e;
  endtask

  task automatic test_reset_mid();
    exp_t z; exp_t e; int n; int idx;
    logic [3:0] ex_an; logic [6:0] ex_led;
    pulse_a(1234, 1'b0);
    q_a.push_back(make_exp(1234, 1'b0, 4));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q_a.delete();
    q_a.push_back(make_exp(0, 1'b0, 4));
    #1;
    z = q_a.pop_front();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy got=%b expected 0", busy_a);
    end
    for (int c = 0; c < 2; c++) begin
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (z.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = z.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led) begin
        errors++; $display("FAIL mid_reset_disp idx=%0d Anode=%b LED_out=%b expected %b %b", idx, an_a, led_a, ex_an, ex_led);
      end
      @(negedge clk);
    end
    // Release and load on the very first rising edge afterwards.
    rst_n = 1'b1; num_a = 13'd5678; hex_a = 1'b0; load_a = 1'b1;
    q_a.push_back(make_exp(5678, 1'b0, 4));
    @(negedge clk); load_a = 1'b0;
    wait_busy_a(n);
    e = q_a.pop_front();
    checks++;
    if (n != int'(e.blen)) begin
      errors++; $display("FAIL post_reset_busy_len got=%0d expected=%0d", n, e.blen);
    end
    for (int c = 0; c < 16; c++) begin
      idx = int'(ref_m[3:2]); ex_an = 4'hF; ex_led = 7'h7F;
      if (e.lit[3-idx]) begin ex_an[3-idx] = 1'b0; ex_led = e.seg[7*(3-idx) +: 7]; end
      checks++;
      if (an_a !== ex_an || led_a !== ex_led) begin
        errors++; $display("FAIL post_reset_scan idx=%0d Anode=%b LED_out=%b expected %b %b", idx, an_a, led_a, ex_an, ex_led);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_overflow();
    test_busy_ignore();
    test_leading();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_scan_display.md
DIGIT_SCAN_DISPLAY -- requirements
Module: digit_scan_display

Interface
REQ-001 SHALL have parameter NUM_W, default 13, giving the input value width (4..32).
REQ-002 SHALL have parameter DIGITS, default 4, giving the displayed digit count (1..8).
REQ-003 SHALL have parameter REFRESH_W, default 20, giving the free-running refresh counter width (>= ceil(log2 DIGITS)+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port num_in  input  NUM_W  unsigned value to display.
REQ-007 SHALL have port load  input  1  single-cycle request to capture num_in and hex_mode.
REQ-008 SHALL have port hex_mode  input  1  1 = hexadecimal digits, 0 = decimal (BCD).
REQ-009 SHALL have port busy  output  1  conversion in progress.
REQ-010 SHALL have port Anode  output  DIGITS  active-low digit enables.
REQ-011 SHALL have port LED_out  output  7  active-low segments, bit6 = a … bit0 = g.

Function
REQ-012 SHALL accept load only when busy=0, capturing num_in and hex_mode on that edge; load while busy=1 SHALL be ignored.
REQ-013 SHALL, in decimal mode, convert with an iterative shift-add-3 algorithm, one shift per cycle, with busy high for exactly NUM_W cycles starting the cycle after the accepted load.
REQ-014 SHALL, in hex mode, hold busy high for exactly 1 cycle and take the digits directly from the num_in nibbles.
REQ-015 SHALL update the display digit register on the same edge that busy falls; the displayed value SHALL NOT change at any other time.
REQ-016 SHALL, when a decimal value is >= 10^DIGITS, show '-' (LED_out 7'b1111110) on every digit.
REQ-017 SHALL free-run a REFRESH_W-bit refresh counter that wraps at all-ones; the scan index is the top ceil(log2 DIGITS) bits.
REQ-018 SHALL, for scan index i < DIGITS, drive Anode bit DIGITS-1-i low (all other bits high) and show digit DIGITS-1-i, so that index 0 shows the most significant digit.
REQ-019 SHALL, for scan index i >= DIGITS, drive Anode and LED_out to all ones.
REQ-020 SHALL decode glyphs 0-9 as 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, and A-F as 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-021 SHALL, in decimal mode, decode any digit code above 9 as all ones (blank).
REQ-022 SHALL drive Anode and LED_out combinationally from the refresh counter and the display register, with no added pipeline delay.

Reset
REQ-023 SHALL, while rst_n=0, clear the refresh counter, busy, the conversion state, and the display register (all digits 0, decimal mode).
REQ-024 SHALL abort any conversion in progress when reset is asserted; after release, the display SHALL show all zeros.
REQ-025 SHALL accept a load on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro LEADING_ZERO_BLANK_EN is defined, blank (Anode bit high, LED_out all ones) every zero digit above the most significant nonzero digit; the least significant digit SHALL always be shown, and dash overflow display SHALL never be blanked.
REQ-027 SHALL, when LEADING_ZERO_BLANK_EN is not defined, show every digit, including leading zeros.

Verification (REFRESH_W=4 unless stated)
REQ-028 SHALL verify: reset, then load 1234 in decimal -> busy high for 13 cycles, then the scan shows Anode 0111/1011/1101/1110 with LED_out 1001111/0010010/0000110/1001100.
REQ-029 SHALL verify: load 13'h1ABF in hex mode -> busy high for 1 cycle, then the digits show 1, A, b, F.
REQ-030 SHALL verify: with DIGITS=3, load 999 -> shows 9,9,9; then load 1000 -> all three digits show 1111110; scan index 3 -> Anode 111, LED_out 1111111.
REQ-031 SHALL verify: load 42, then pulse load=1 with num_in=77 during busy -> the second load is ignored and 42 is displayed.
REQ-032 SHALL verify: load 7 -> with LEADING_ZERO_BLANK_EN, only the Anode 1110 digit is lit, showing 0001111; without the macro, the display shows 0,0,0,7.
REQ-033 SHALL verify: assert rst_n=0 mid-conversion at cycle 5 -> busy=0 immediately, the display shows 0000, and a new load after release completes normally.
